// File: rtl/ace_rd_responder_if.sv
// ACE read-side bus bundle between the instruction-fetch master and its
// downstream responder: AR/R/RACK read channels plus AC/CR/CD snoop channels.
interface ace_rd_responder_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [3:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;
   logic                  rack;
   logic                  acvalid;
   logic                  acready;
   logic [ADDR_WIDTH-1:0] acaddr;
   logic [3:0]            acsnoop;
   logic                  crvalid;
   logic                  crready;
   logic [4:0]            crresp;
   logic                  cdvalid;
   logic                  cdready;
   logic                  cdlast;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready, rack,
      output acvalid, acaddr, acsnoop,
      input  acready,
      input  crvalid, crresp,
      output crready,
      input  cdvalid, cdlast,
      output cdready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready, rack,
      input  acvalid, acaddr, acsnoop,
      output acready,
      output crvalid, crresp,
      input  crready,
      output cdvalid, cdlast,
      input  cdready
   );
endinterface

// File: rtl/ace_rd_responder.sv
// Downstream end of the instruction-fetch ACE port. Serves one-line-per-beat
// reads from an internal backing RAM (AR -> R -> RACK) and, independently,
// issues AC snoops on request and reports the collected CR response.
module ace_rd_responder #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   ace_rd_responder_if.slave            bus,
   input  logic                         snp_req_valid,
   output logic                         snp_req_ready,
   input  logic [ADDR_WIDTH-1:0]        snp_req_addr,
   input  logic [3:0]                   snp_req_type,
   output logic                         snp_done,
   output logic [4:0]                   snp_crresp,
   input  logic                         mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
   input  logic [DATA_WIDTH-1:0]        mem_wdata
);
   localparam int LINE_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      RD_IDLE     = 2'd0,
      RD_FETCH    = 2'd1,
      RD_RESP     = 2'd2,
      RD_WAIT_ACK = 2'd3
   } rd_state_t;

   typedef enum logic [1:0] {
      SN_IDLE = 2'd0,
      SN_AC   = 2'd1,
      SN_CR   = 2'd2,
      SN_CD   = 2'd3
   } sn_state_t;

   // ---------------- backing RAM ----------------
   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

   // Backdoor line write port; a same-cycle read sees the previous contents.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_r[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------- read path ----------------
   rd_state_t             rd_state_r, rd_next_s;
   logic                  arready_r, arready_nx_s;
   logic                  rvalid_r, rvalid_nx_s;
   logic                  rlast_r;
   logic [ID_WIDTH-1:0]   rid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic [ID_WIDTH-1:0]   id_r, id_nx_s;
   logic [LINE_W-1:0]     idx_r, idx_nx_s;
   logic [7:0]            cnt_r, cnt_nx_s;
   logic                  err_r, err_nx_s;
   logic                  ar_hs_s, r_hs_s;

   assign ar_hs_s = bus.arvalid & arready_r;
   assign r_hs_s  = rvalid_r & bus.rready;

   // Read FSM state, control outputs and the beat registers loaded from RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_r <= RD_IDLE;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
         rlast_r    <= 1'b0;
         rid_r      <= {ID_WIDTH{1'b0}};
         rdata_r    <= {DATA_WIDTH{1'b0}};
         rresp_r    <= 2'b00;
         id_r       <= {ID_WIDTH{1'b0}};
         idx_r      <= {LINE_W{1'b0}};
         cnt_r      <= 8'd0;
         err_r      <= 1'b0;
      end else begin
         rd_state_r <= rd_next_s;
         arready_r  <= arready_nx_s;
         rvalid_r   <= rvalid_nx_s;
         id_r       <= id_nx_s;
         idx_r      <= idx_nx_s;
         cnt_r      <= cnt_nx_s;
         err_r      <= err_nx_s;
         if (rd_state_r == RD_FETCH) begin
            rid_r   <= id_r;
            rlast_r <= (cnt_r == 8'd0);
            rresp_r <= err_r ? 2'b10 : 2'b00;
            rdata_r <= err_r ? {DATA_WIDTH{1'b0}} : mem_r[idx_r];
         end
      end
   end

   // Read FSM transitions: one outstanding read, RACK closes the transaction.
   always_comb begin
      rd_next_s = rd_state_r;
      case (rd_state_r)
         RD_IDLE: begin
            if (ar_hs_s) rd_next_s = RD_FETCH;
            else         rd_next_s = RD_IDLE;
         end
         RD_FETCH: rd_next_s = RD_RESP;
         RD_RESP: begin
            if (r_hs_s) rd_next_s = rlast_r ? RD_WAIT_ACK : RD_FETCH;
            else        rd_next_s = RD_RESP;
         end
         RD_WAIT_ACK: begin
            if (bus.rack) rd_next_s = RD_IDLE;
            else          rd_next_s = RD_WAIT_ACK;
         end
         default: rd_next_s = RD_IDLE;
      endcase
   end

   // Next values of the read handshakes and of the burst bookkeeping.
   always_comb begin
      arready_nx_s = (rd_next_s == RD_IDLE);
      rvalid_nx_s  = (rd_next_s == RD_RESP);
      id_nx_s      = id_r;
      idx_nx_s     = idx_r;
      cnt_nx_s     = cnt_r;
      err_nx_s     = err_r;
      if (ar_hs_s) begin
         id_nx_s  = bus.arid;
         idx_nx_s = bus.araddr[5 +: LINE_W];
         cnt_nx_s = bus.arlen;
         err_nx_s = (bus.arsize != 3'd5) || (bus.arburst != 2'b01);
      end else if (r_hs_s && !rlast_r) begin
         // Next line of the burst; the index wraps around the RAM.
         cnt_nx_s = cnt_r - 8'd1;
         idx_nx_s = idx_r + {{(LINE_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   assign bus.arready = arready_r;
   assign bus.rvalid  = rvalid_r;
   assign bus.rlast   = rlast_r;
   assign bus.rid     = rid_r;
   assign bus.rdata   = rdata_r;
   assign bus.rresp   = {2'b00, rresp_r};

   // Only the line-index bits of the read address select data.
   logic unused_addr_bits_s;
   assign unused_addr_bits_s = ^{bus.araddr[4:0], bus.araddr[ADDR_WIDTH-1:5+LINE_W]};

   // ---------------- snoop path ----------------
   sn_state_t             sn_state_r, sn_next_s;
   logic                  snp_req_ready_r, snp_req_ready_nx_s;
   logic                  acvalid_r, acvalid_nx_s;
   logic [ADDR_WIDTH-1:0] acaddr_r, acaddr_nx_s;
   logic [3:0]            acsnoop_r, acsnoop_nx_s;
   logic                  snp_done_r, snp_done_nx_s;
   logic [4:0]            snp_crresp_r, snp_crresp_nx_s;
   logic                  req_hs_s, cr_take_s;

   assign req_hs_s  = snp_req_valid & snp_req_ready_r;
   assign cr_take_s = (sn_state_r == SN_CR) & bus.crvalid;

   // Snoop FSM state and registered snoop-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sn_state_r      <= SN_IDLE;
         snp_req_ready_r <= 1'b0;
         acvalid_r       <= 1'b0;
         acaddr_r        <= {ADDR_WIDTH{1'b0}};
         acsnoop_r       <= 4'd0;
         snp_done_r      <= 1'b0;
         snp_crresp_r    <= 5'd0;
      end else begin
         sn_state_r      <= sn_next_s;
         snp_req_ready_r <= snp_req_ready_nx_s;
         acvalid_r       <= acvalid_nx_s;
         acaddr_r        <= acaddr_nx_s;
         acsnoop_r       <= acsnoop_nx_s;
         snp_done_r      <= snp_done_nx_s;
         snp_crresp_r    <= snp_crresp_nx_s;
      end
   end

   // Snoop FSM transitions; CR is only looked at once the AC handshake is done.
   always_comb begin
      sn_next_s = sn_state_r;
      case (sn_state_r)
         SN_IDLE: begin
            if (req_hs_s) sn_next_s = SN_AC;
            else          sn_next_s = SN_IDLE;
         end
         SN_AC: begin
            if (acvalid_r && bus.acready) sn_next_s = SN_CR;
            else                          sn_next_s = SN_AC;
         end
         SN_CR: begin
            if (bus.crvalid) sn_next_s = bus.crresp[0] ? SN_CD : SN_IDLE;
            else             sn_next_s = SN_CR;
         end
         SN_CD: begin
            if (bus.cdvalid && bus.cdlast) sn_next_s = SN_IDLE;
            else                           sn_next_s = SN_CD;
         end
         default: sn_next_s = SN_IDLE;
      endcase
   end

   // Next values of the snoop handshakes, AC payload and completion report.
   always_comb begin
      snp_req_ready_nx_s = (sn_next_s == SN_IDLE);
      acvalid_nx_s       = (sn_next_s == SN_AC);
      snp_done_nx_s      = (cr_take_s && !bus.crresp[0]) ||
                           ((sn_state_r == SN_CD) && bus.cdvalid && bus.cdlast);
      if (req_hs_s) begin
         acaddr_nx_s  = snp_req_addr;
         acsnoop_nx_s = snp_req_type;
      end else begin
         acaddr_nx_s  = acaddr_r;
         acsnoop_nx_s = acsnoop_r;
      end
      if (cr_take_s) snp_crresp_nx_s = bus.crresp;
      else           snp_crresp_nx_s = snp_crresp_r;
   end

   assign snp_req_ready = snp_req_ready_r;
   assign bus.acvalid   = acvalid_r;
   assign bus.acaddr    = acaddr_r;
   assign bus.acsnoop   = acsnoop_r;
   assign snp_done      = snp_done_r;
   assign snp_crresp    = snp_crresp_r;
   assign bus.crready   = 1'b1;
   assign bus.cdready   = 1'b1;
endmodule

// File: tb/tb_ace_rd_responder.sv
// Self-checking bench for ace_rd_responder: randomized reads and snoops
// compared against a line-array memory model and the channel rules.
module tb_ace_rd_responder;
   localparam int DW = 256;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int MD = 1024;
   localparam int LW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ace_rd_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) ace ();

   logic          snp_req_valid, snp_req_ready, snp_done, mem_we;
   logic [AW-1:0] snp_req_addr;
   logic [3:0]    snp_req_type;
   logic [4:0]    snp_crresp;
   logic [LW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   ace_rd_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(MD)) dut (
      .clk(clk), .rst(rst), .bus(ace),
      .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
      .snp_req_addr(snp_req_addr), .snp_req_type(snp_req_type),
      .snp_done(snp_done), .snp_crresp(snp_crresp),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );

   logic [DW-1:0] model_mem [MD];
   int tests_run = 0;
   int tests_failed = 0;

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_write(input int line, input logic [DW-1:0] d);
      mem_we = 1'b1; mem_waddr = line[LW-1:0]; mem_wdata = d;
      step();
      mem_we = 1'b0;
      model_mem[line] = d;
   endtask

   // One complete read transaction checked against the memory model.
   task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int smin, input int smax);
      int cyc, stall, line, nwait;
      logic err, exp_last;
      logic [DW-1:0] exp_d;
      logic [3:0] exp_resp;
      err = (size != 3'd5) || (burst != 2'b01);
      line = int'(addr[5 +: LW]);
      exp_resp = {2'b00, err ? 2'b10 : 2'b00};
      cyc = 0;
      while (ace.arready !== 1'b1 && cyc < 50) begin step(); cyc++; end
      tests_run++;
      if (ace.arready !== 1'b1) begin
         tests_failed++; $display("FAIL ar_ready_wait: arready=%b want 1", ace.arready);
      end
      ace.arid = id; ace.araddr = addr; ace.arlen = len;
      ace.arsize = size; ace.arburst = burst; ace.arvalid = 1'b1;
      step();
      ace.arvalid = 1'b0;
      tests_run++;
      if (ace.rvalid !== 1'b0 || ace.arready !== 1'b0) begin
         tests_failed++;
         $display("FAIL r_latency_early: rvalid=%b arready=%b want 0 0", ace.rvalid, ace.arready);
      end
      step();
      for (int k = 0; k <= int'(len); k++) begin
         exp_d = err ? {DW{1'b0}} : model_mem[(line + k) % MD];
         exp_last = (k == int'(len));
         stall = int'($urandom_range(smax, smin));
         for (int s = 0; s <= stall; s++) begin
            ace.rack = (s == 1);
            tests_run++;
            if (ace.rvalid !== 1'b1 || ace.rdata !== exp_d || ace.rid !== id ||
                ace.rlast !== exp_last || ace.rresp !== exp_resp) begin
               tests_failed++;
               $display("FAIL r_beat%0d: rvalid=%b rid=%h rlast=%b rresp=%h rdata=%h want 1 %h %b %h %h",
                        k, ace.rvalid, ace.rid, ace.rlast, ace.rresp, ace.rdata,
                        id, exp_last, exp_resp, exp_d);
            end
            ace.rready = (s == stall);
            step();
         end
         ace.rready = 1'b0; ace.rack = 1'b0;
         if (!exp_last) begin
            tests_run++;
            if (ace.rvalid !== 1'b0) begin
               tests_failed++; $display("FAIL r_gap%0d: rvalid=%b want 0", k, ace.rvalid);
            end
            step();
         end
      end
      nwait = int'($urandom_range(3, 1));
      for (int w = 0; w < nwait; w++) begin
         tests_run++;
         if (ace.arready !== 1'b0 || ace.rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_ack: arready=%b rvalid=%b want 0 0", ace.arready, ace.rvalid);
         end
         step();
      end
      ace.rack = 1'b1;
      step();
      ace.rack = 1'b0;
      tests_run++;
      if (ace.arready !== 1'b1) begin
         tests_failed++; $display("FAIL after_rack: arready=%b want 1", ace.arready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ace.arvalid = 1'b0; ace.arid = '0; ace.araddr = '0; ace.arlen = 8'd0;
      ace.arsize = 3'd0; ace.arburst = 2'b00; ace.rready = 1'b0; ace.rack = 1'b0;
      ace.acready = 1'b0; ace.crvalid = 1'b0; ace.crresp = 5'd0;
      ace.cdvalid = 1'b0; ace.cdlast = 1'b0;
      snp_req_valid = 1'b0; snp_req_addr = '0; snp_req_type = 4'd0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      step(); step();
      tests_run++;
      if (ace.arready !== 1'b0 || ace.rvalid !== 1'b0 || ace.rlast !== 1'b0 ||
          ace.rid !== 4'd0 || ace.rdata !== {DW{1'b0}} || ace.rresp !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_read: arready=%b rvalid=%b rlast=%b rid=%h rresp=%h want all 0",
                  ace.arready, ace.rvalid, ace.rlast, ace.rid, ace.rresp);
      end
      tests_run++;
      if (ace.acvalid !== 1'b0 || ace.acaddr !== 32'd0 || ace.acsnoop !== 4'd0 ||
          snp_req_ready !== 1'b0 || snp_done !== 1'b0 || snp_crresp !== 5'd0 ||
          ace.crready !== 1'b1 || ace.cdready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_snoop: acvalid=%b acaddr=%h acsnoop=%h srdy=%b done=%b cr=%h crready=%b cdready=%b want 0 0 0 0 0 0 1 1",
                  ace.acvalid, ace.acaddr, ace.acsnoop, snp_req_ready, snp_done,
                  snp_crresp, ace.crready, ace.cdready);
      end
      rst = 1'b0;
      step();
      tests_run++;
      if (ace.arready !== 1'b1 || snp_req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release: arready=%b snp_req_ready=%b want 1 1", ace.arready, snp_req_ready);
      end
   endtask

   task automatic test_basic_read();
      mem_write(3, {32{8'hA5}});
      do_read(4'd2, 32'h60, 8'd0, 3'd5, 2'b01, 0, 0);
   endtask

   task automatic test_wrap_read();
      mem_write(1023, rand_line());
      mem_write(0, rand_line());
      mem_write(1, rand_line());
      do_read(4'($urandom), 32'h7FE0, 8'd2, 3'd5, 2'b01, 0, 1);
   endtask

   task automatic test_backpressure();
      do_read(4'($urandom), $urandom, 8'd1, 3'd5, 2'b01, 5, 5);
   endtask

   task automatic test_error_read();
      do_read(4'd7, 32'h1240, 8'd0, 3'd3, 2'b01, 0, 2);
      do_read(4'd9, 32'h0080, 8'd1, 3'd5, 2'b10, 0, 2);
   endtask

   // A backdoor write to the line being fetched must not be visible yet.
   task automatic test_fetch_collision();
      logic [DW-1:0] old_d, new_d;
      old_d = model_mem[77];
      new_d = ~old_d;
      tests_run++;
      if (ace.arready !== 1'b1) begin
         tests_failed++; $display("FAIL coll_arready: arready=%b want 1", ace.arready);
      end
      ace.arid = 4'd5; ace.araddr = 32'(77) << 5; ace.arlen = 8'd0;
      ace.arsize = 3'd5; ace.arburst = 2'b01; ace.arvalid = 1'b1;
      step();
      ace.arvalid = 1'b0;
      mem_we = 1'b1; mem_waddr = 10'd77; mem_wdata = new_d;
      step();
      mem_we = 1'b0;
      tests_run++;
      if (ace.rvalid !== 1'b1 || ace.rdata !== old_d) begin
         tests_failed++;
         $display("FAIL coll_old_data: rvalid=%b rdata=%h want 1 %h", ace.rvalid, ace.rdata, old_d);
      end
      model_mem[77] = new_d;
      ace.rready = 1'b1; step(); ace.rready = 1'b0;
      ace.rack = 1'b1; step(); ace.rack = 1'b0;
      do_read(4'd6, 32'(77) << 5, 8'd0, 3'd5, 2'b01, 0, 0);
   endtask

   task automatic test_random_reads();
      logic [2:0] sz;
      logic [1:0] bu;
      for (int i = 0; i < 10; i++) begin
         sz = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'd5;
         bu = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b01;
         do_read(4'($urandom), $urandom, 8'($urandom_range(3, 0)), sz, bu, 0, 3);
      end
   endtask

   // One snoop: AC with random backpressure, CR (with a decoy during the
   // AC handshake), optional CD beats, then the completion pulse.
   task automatic test_snoop(input logic [AW-1:0] addr, input logic [3:0] typ, input logic [4:0] cr);
      int cyc, n;
      cyc = 0;
      while (snp_req_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
      tests_run++;
      if (snp_req_ready !== 1'b1) begin
         tests_failed++; $display("FAIL snp_ready_wait: snp_req_ready=%b want 1", snp_req_ready);
      end
      snp_req_valid = 1'b1; snp_req_addr = addr; snp_req_type = typ;
      step();
      snp_req_valid = 1'b0;
      n = int'($urandom_range(3, 0));
      for (int i = 0; i <= n; i++) begin
         tests_run++;
         if (ace.acvalid !== 1'b1 || ace.acaddr !== addr || ace.acsnoop !== typ ||
             snp_done !== 1'b0 || snp_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ac_hold: acvalid=%b acaddr=%h acsnoop=%h done=%b srdy=%b want 1 %h %h 0 0",
                     ace.acvalid, ace.acaddr, ace.acsnoop, snp_done, snp_req_ready, addr, typ);
         end
         if (i == n) begin
            ace.acready = 1'b1; ace.crvalid = 1'b1; ace.crresp = cr ^ 5'h1F;
         end
         step();
      end
      ace.acready = 1'b0; ace.crvalid = 1'b0;
      n = int'($urandom_range(2, 0));
      for (int i = 0; i <= n; i++) begin
         tests_run++;
         if (ace.acvalid !== 1'b0 || snp_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL cr_wait: acvalid=%b done=%b want 0 0", ace.acvalid, snp_done);
         end
         if (i < n) step();
      end
      ace.crvalid = 1'b1; ace.crresp = cr;
      step();
      ace.crvalid = 1'b0; ace.crresp = 5'd0;
      if (cr[0]) begin
         tests_run++;
         if (snp_done !== 1'b0) begin
            tests_failed++; $display("FAIL cd_early_done: done=%b want 0", snp_done);
         end
         n = int'($urandom_range(3, 1));
         for (int i = 0; i < n; i++) begin
            ace.cdvalid = 1'b1; ace.cdlast = (i == n - 1);
            step();
            ace.cdvalid = 1'b0; ace.cdlast = 1'b0;
            if (i < n - 1) begin
               tests_run++;
               if (snp_done !== 1'b0) begin
                  tests_failed++; $display("FAIL cd_beat%0d_done: done=%b want 0", i, snp_done);
               end
            end
         end
      end
      tests_run++;
      if (snp_done !== 1'b1 || snp_crresp !== cr) begin
         tests_failed++;
         $display("FAIL snp_done: done=%b crresp=%h want 1 %h", snp_done, snp_crresp, cr);
      end
      step();
      tests_run++;
      if (snp_done !== 1'b0 || snp_req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL snp_after: done=%b snp_req_ready=%b want 0 1", snp_done, snp_req_ready);
      end
   endtask

   task automatic test_random_snoops();
      for (int i = 0; i < 6; i++) test_snoop($urandom, 4'($urandom), 5'($urandom));
   endtask

   // Reset asserted with a read in RESP and a snoop in AC.
   task automatic test_reset_mid();
      ace.arid = 4'd1; ace.araddr = 32'h200; ace.arlen = 8'd1;
      ace.arsize = 3'd5; ace.arburst = 2'b01; ace.arvalid = 1'b1;
      snp_req_valid = 1'b1; snp_req_addr = 32'h300; snp_req_type = 4'h2;
      step();
      ace.arvalid = 1'b0; snp_req_valid = 1'b0;
      step();
      tests_run++;
      if (ace.rvalid !== 1'b1 || ace.acvalid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_setup: rvalid=%b acvalid=%b want 1 1", ace.rvalid, ace.acvalid);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (ace.rvalid !== 1'b0 || ace.acvalid !== 1'b0 || ace.arready !== 1'b0 ||
          snp_req_ready !== 1'b0 || ace.crready !== 1'b1 || ace.cdready !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_async: rvalid=%b acvalid=%b arready=%b srdy=%b crready=%b cdready=%b want 0 0 0 0 1 1",
                  ace.rvalid, ace.acvalid, ace.arready, snp_req_ready, ace.crready, ace.cdready);
      end
      step();
      rst = 1'b0;
      tests_run++;
      if (ace.arready !== 1'b0 || snp_req_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_release0: arready=%b snp_req_ready=%b want 0 0", ace.arready, snp_req_ready);
      end
      step();
      tests_run++;
      if (ace.arready !== 1'b1 || snp_req_ready !== 1'b1 || ace.rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_release1: arready=%b snp_req_ready=%b rvalid=%b want 1 1 0",
                  ace.arready, snp_req_ready, ace.rvalid);
      end
      do_read(4'd3, 32'h200, 8'd1, 3'd5, 2'b01, 0, 2);
      test_snoop(32'h300, 4'h2, 5'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      for (int i = 0; i < MD; i++) mem_write(i, rand_line());
      test_basic_read();
      test_wrap_read();
      test_backpressure();
      test_error_read();
      test_fetch_collision();
      test_random_reads();
      test_snoop(32'h100, 4'h9, 5'h00);
      test_snoop(32'h100, 4'h9, 5'h01);
      test_random_snoops();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
